// File: rtl/dmem_ctrl_if.sv
// CPU data-memory request bus between the MEM stage (master) and dmem_ctrl (slave).
//   mem_addr   byte address of the request
//   mem_read   read request, held until mem_stall is low
//   mem_write  write request (wins over mem_read when both are high)
//   mem_wdata  write data
//   mem_rdata  read data returned to the CPU
//   mem_stall  high while the CPU must hold its request
interface dmem_ctrl_if;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;

  modport master (
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_wdata,
    input  mem_rdata,
    input  mem_stall
  );

  modport slave (
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_wdata,
    output mem_rdata,
    output mem_stall
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: responder end of the CPU data-memory bus.
//   - RAM region (below IO_BASE): synchronous on-chip RAM, 1-cycle read latency.
//   - IO region (IO_BASE and above): registered valid/ready peripheral request with timeout.
//   - Secondary DMA port into the RAM, granted when the CPU is idle or when the DMA
//     has been denied for STARVE_MAX consecutive request cycles.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cpu                  CPU request bus (slave modport)
//   ram_*                RAM address / write enable / write data / read data
//   io_*                 peripheral request (registered), ready/data return, timeout pulse
//   dma_*                DMA request, 1-cycle grant, read data and read-data valid
module dmem_ctrl #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_0000,
  parameter int unsigned IO_TIMEOUT = 255,
  parameter int unsigned STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_ctrl_if.slave        cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  output logic              io_we,
  output logic              io_valid,
  input  logic              io_ready,
  input  logic [31:0]       io_rdata,
  output logic              io_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic [31:0]       dma_rdata,
  output logic              dma_rvalid
);

  localparam int unsigned TmoW    = $clog2(IO_TIMEOUT + 1);
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [31:0] AbortData = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {StIdle, StRamRd, StIoWait, StDmaRd} stateT;

  stateT               stateQ;
  logic [31:0]         rdataQ;
  logic [31:0]         ioAddrQ;
  logic [31:0]         ioWdataQ;
  logic                ioWeQ;
  logic                ioValidQ;
  logic [TmoW-1:0]     tmoQ;
  logic [StarveW-1:0]  starveQ;
  logic                dmaRvalidQ;

  logic                cpuReq;
  logic                isIo;
  logic [ADDR_W-1:0]   cpuWord;
  logic                starveHit;
  logic                tmoHit;
  logic                dmaGnt;
  logic                weComb;
  logic                stallComb;
  logic [ADDR_W-1:0]   ramAddrComb;
  logic [31:0]         ramWdataComb;
  logic [31:0]         rdataComb;

  assign cpuReq    = cpu.mem_read | cpu.mem_write;
  assign isIo      = (cpu.mem_addr >= IO_BASE);
  // Upper address bits inside the RAM region simply alias onto the RAM.
  assign cpuWord   = cpu.mem_addr[ADDR_W+1:2];
  assign starveHit = (starveQ == StarveW'(STARVE_MAX));
  // io_ready in the final wait cycle still completes normally.
  assign tmoHit    = (stateQ == StIoWait) && !io_ready && (tmoQ == TmoW'(IO_TIMEOUT));
  // DMA wins in IDLE when the CPU is quiet, or unconditionally once starved.
  assign dmaGnt    = (stateQ == StIdle) && dma_req && (!cpuReq || starveHit);

  always_comb begin
    ramAddrComb  = cpuWord;
    ramWdataComb = cpu.mem_wdata;
    weComb       = 1'b0;
    stallComb    = 1'b0;
    rdataComb    = rdataQ;
    unique case (stateQ)
      StIdle: begin
        if (dmaGnt) begin
          ramAddrComb  = dma_addr;
          ramWdataComb = dma_wdata;
          weComb       = dma_we;
          stallComb    = cpuReq;
        end else if (cpu.mem_write && !isIo) begin
          weComb = 1'b1;
        end else if (cpuReq) begin
          // RAM read or any IO access needs at least one more cycle.
          stallComb = 1'b1;
        end
      end
      StRamRd: begin
        rdataComb = ram_rdata;
      end
      StIoWait: begin
        if (io_ready) begin
          rdataComb = io_rdata;
        end else if (tmoHit) begin
          rdataComb = AbortData;
        end else begin
          stallComb = 1'b1;
        end
      end
      StDmaRd: begin
        stallComb = cpuReq;
      end
      default: ;
    endcase
  end

  // Gate the combinational strobes so nothing leaks out while reset is held.
  assign ram_addr      = ramAddrComb;
  assign ram_wdata     = ramWdataComb;
  assign ram_we        = rst_n & weComb;
  assign cpu.mem_stall = rst_n & stallComb;
  assign cpu.mem_rdata = rdataComb;
  assign io_err        = rst_n & tmoHit;
  assign dma_gnt       = rst_n & dmaGnt;
  assign io_addr       = ioAddrQ;
  assign io_wdata      = ioWdataQ;
  assign io_we         = ioWeQ;
  assign io_valid      = ioValidQ;
  assign dma_rdata     = ram_rdata;
  assign dma_rvalid    = dmaRvalidQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ     <= StIdle;
      rdataQ     <= '0;
      ioAddrQ    <= '0;
      ioWdataQ   <= '0;
      ioWeQ      <= 1'b0;
      ioValidQ   <= 1'b0;
      tmoQ       <= '0;
      starveQ    <= '0;
      dmaRvalidQ <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          tmoQ <= '0;
          if (dmaGnt) begin
            if (!dma_we) begin
              stateQ     <= StDmaRd;
              dmaRvalidQ <= 1'b1;
            end
          end else if (cpuReq && isIo) begin
            stateQ   <= StIoWait;
            ioValidQ <= 1'b1;
            ioAddrQ  <= cpu.mem_addr;
            ioWdataQ <= cpu.mem_wdata;
            ioWeQ    <= cpu.mem_write;
          end else if (cpu.mem_read && !cpu.mem_write) begin
            stateQ <= StRamRd;
          end
        end
        StRamRd: begin
          rdataQ <= ram_rdata;
          stateQ <= StIdle;
        end
        StIoWait: begin
          if (io_ready) begin
            rdataQ   <= io_rdata;
            ioValidQ <= 1'b0;
            stateQ   <= StIdle;
          end else if (tmoHit) begin
            rdataQ   <= AbortData;
            ioValidQ <= 1'b0;
            stateQ   <= StIdle;
          end else begin
            tmoQ <= tmoQ + TmoW'(1);
          end
        end
        StDmaRd: begin
          dmaRvalidQ <= 1'b0;
          stateQ     <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase

      // Denied-request counter; saturates so a long-starved DMA keeps priority.
      if (dmaGnt) begin
        starveQ <= '0;
      end else if (dma_req && !starveHit) begin
        starveQ <= starveQ + StarveW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_valid;
  logic        io_ready;
  logic [31:0] io_rdata;
  logic        io_err;
  logic        dma_req;
  logic        dma_we;
  logic [11:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  int nTests = 0;
  int nFail  = 0;

  dmem_ctrl_if cpuBus ();

  dmem_ctrl #(
    .ADDR_W     (12),
    .IO_BASE    (32'hFFFF_0000),
    .IO_TIMEOUT (255),
    .STARVE_MAX (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (cpuBus.slave),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_we      (io_we),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .io_rdata   (io_rdata),
    .io_err     (io_err),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rdata  (dma_rdata),
    .dma_rvalid (dma_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, 1-cycle read latency.
  logic [31:0] ramMem [4096];
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One CPU access; returns stall cycles, delivered data and first-cycle RAM strobes.
  task automatic cpuAccess(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wdata, output int stalls,
                           output logic [31:0] rdata, output logic firstWe,
                           output logic [11:0] firstWord);
    int n;
    @(posedge clk); #1;
    cpuBus.mem_addr  = addr;
    cpuBus.mem_read  = rd;
    cpuBus.mem_write = wr;
    cpuBus.mem_wdata = wdata;
    @(negedge clk);
    firstWe   = ram_we;
    firstWord = ram_addr;
    n = 0;
    while (cpuBus.mem_stall && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (cpuBus.mem_stall) begin
      nTests++;
      nFail++;
      $display("FAIL cpu_access_timeout: stall still 1 after %0d cycles, expected 0", n);
    end
    stalls = n;
    rdata  = cpuBus.mem_rdata;
    @(posedge clk); #1;
    cpuBus.mem_read  = 1'b0;
    cpuBus.mem_write = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          expStalls;
    logic        expWe;
    logic [11:0] expWord;
    logic [31:0] expRdata;
  } vecT;

  vecT vecs [10];

  initial begin
    int          stalls;
    logic [31:0] rdata;
    logic        we;
    logic [11:0] word;
    int          cnt;
    int          firstGnt;
    int          k;

    vecs[0] = '{32'h0000_0010, 1'b0, 1'b1, 32'hCAFE_F00D, 0, 1'b1, 12'h004, 32'h0};
    vecs[1] = '{32'h0000_0010, 1'b1, 1'b0, 32'h0,         1, 1'b0, 12'h004, 32'hCAFE_F00D};
    vecs[2] = '{32'h0000_0014, 1'b0, 1'b1, 32'h1111_2222, 0, 1'b1, 12'h005, 32'h0};
    vecs[3] = '{32'h0000_4010, 1'b0, 1'b1, 32'hA5A5_A5A5, 0, 1'b1, 12'h004, 32'h0};
    vecs[4] = '{32'h0000_0010, 1'b1, 1'b0, 32'h0,         1, 1'b0, 12'h004, 32'hA5A5_A5A5};
    vecs[5] = '{32'h0000_0014, 1'b1, 1'b0, 32'h0,         1, 1'b0, 12'h005, 32'h1111_2222};
    vecs[6] = '{32'h0000_0020, 1'b1, 1'b1, 32'h0000_0055, 0, 1'b1, 12'h008, 32'h0};
    vecs[7] = '{32'h0000_0020, 1'b1, 1'b0, 32'h0,         1, 1'b0, 12'h008, 32'h0000_0055};
    vecs[8] = '{32'hFFFE_FFFC, 1'b0, 1'b1, 32'h0BAD_F00D, 0, 1'b1, 12'hFFF, 32'h0};
    vecs[9] = '{32'h0000_3FFC, 1'b1, 1'b0, 32'h0,         1, 1'b0, 12'hFFF, 32'h0BAD_F00D};

    // Reset with requests present: strobes must stay quiet.
    rst_n            = 1'b0;
    cpuBus.mem_addr  = 32'h0000_0010;
    cpuBus.mem_read  = 1'b0;
    cpuBus.mem_write = 1'b1;
    cpuBus.mem_wdata = 32'h1;
    io_ready         = 1'b0;
    io_rdata         = 32'h0;
    dma_req          = 1'b1;
    dma_we           = 1'b1;
    dma_addr         = 12'h0;
    dma_wdata        = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ram_we", {31'h0, ram_we}, 32'h0);
    check("rst_stall", {31'h0, cpuBus.mem_stall}, 32'h0);
    check("rst_dma_gnt", {31'h0, dma_gnt}, 32'h0);
    check("rst_io_valid", {31'h0, io_valid}, 32'h0);
    check("rst_io_err", {31'h0, io_err}, 32'h0);
    check("rst_dma_rvalid", {31'h0, dma_rvalid}, 32'h0);
    check("rst_rdata", cpuBus.mem_rdata, 32'h0);
    cpuBus.mem_write = 1'b0;
    dma_req          = 1'b0;
    dma_we           = 1'b0;
    rst_n            = 1'b1;

    // Table-driven RAM accesses.
    for (int i = 0; i < 10; i++) begin
      cpuAccess(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata, stalls, rdata, we, word);
      check($sformatf("vec%0d_stalls", i), stalls, vecs[i].expStalls);
      check($sformatf("vec%0d_we", i), {31'h0, we}, {31'h0, vecs[i].expWe});
      check($sformatf("vec%0d_word", i), {20'h0, word}, {20'h0, vecs[i].expWord});
      if (vecs[i].rd && !vecs[i].wr)
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].expRdata);
    end

    // IO read, io_ready in the third wait cycle.
    @(posedge clk); #1;
    cpuBus.mem_addr = 32'hFFFF_0004;
    cpuBus.mem_read = 1'b1;
    @(negedge clk);
    check("ior_idle_stall", {31'h0, cpuBus.mem_stall}, 32'h1);
    check("ior_idle_valid", {31'h0, io_valid}, 32'h0);
    cnt = 0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 3) begin
        io_ready = 1'b1;
        io_rdata = 32'h1234_5678;
      end
      @(negedge clk);
      if (io_valid) cnt++;
      check($sformatf("ior_stall_c%0d", c), {31'h0, cpuBus.mem_stall}, (c == 3) ? 32'h0 : 32'h1);
      if (c == 1) begin
        check("ior_io_addr", io_addr, 32'hFFFF_0004);
        check("ior_io_we", {31'h0, io_we}, 32'h0);
      end
    end
    check("ior_rdata", cpuBus.mem_rdata, 32'h1234_5678);
    check("ior_valid_cycles", cnt, 3);
    @(posedge clk); #1;
    io_ready        = 1'b0;
    io_rdata        = 32'h0;
    cpuBus.mem_read = 1'b0;
    @(negedge clk);
    check("ior_valid_fall", {31'h0, io_valid}, 32'h0);
    check("ior_rdata_held", cpuBus.mem_rdata, 32'h1234_5678);

    // IO write that never gets io_ready: timeout abort.
    @(posedge clk); #1;
    cpuBus.mem_addr  = 32'hFFFF_0100;
    cpuBus.mem_wdata = 32'h0000_0077;
    cpuBus.mem_write = 1'b1;
    @(negedge clk);
    check("iot_idle_stall", {31'h0, cpuBus.mem_stall}, 32'h1);
    cnt = 0;
    k   = 0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (io_err) break;
      if (io_valid) cnt++;
    end
    check("iot_err_seen", {31'h0, io_err}, 32'h1);
    check("iot_wait_cycles", cnt, 255);
    check("iot_stall", {31'h0, cpuBus.mem_stall}, 32'h0);
    check("iot_rdata", cpuBus.mem_rdata, 32'hDEAD_BEEF);
    check("iot_io_we", {31'h0, io_we}, 32'h1);
    check("iot_io_wdata", io_wdata, 32'h0000_0077);
    @(posedge clk); #1;
    cpuBus.mem_write = 1'b0;
    @(negedge clk);
    check("iot_err_pulse", {31'h0, io_err}, 32'h0);
    check("iot_valid_fall", {31'h0, io_valid}, 32'h0);
    check("iot_rdata_held", cpuBus.mem_rdata, 32'hDEAD_BEEF);
    cpuAccess(32'h0000_0014, 1'b1, 1'b0, 32'h0, stalls, rdata, we, word);
    check("iot_idle_after", stalls, 1);

    // DMA read of word 7 while the CPU is idle.
    cpuAccess(32'h0000_001C, 1'b0, 1'b1, 32'h7777_0007, stalls, rdata, we, word);
    @(posedge clk); #1;
    dma_req  = 1'b1;
    dma_we   = 1'b0;
    dma_addr = 12'd7;
    @(negedge clk);
    check("dmar_gnt", {31'h0, dma_gnt}, 32'h1);
    check("dmar_addr", {20'h0, ram_addr}, 32'h7);
    check("dmar_we", {31'h0, ram_we}, 32'h0);
    @(posedge clk); #1;
    dma_req         = 1'b0;
    cpuBus.mem_addr = 32'h0000_0010;
    cpuBus.mem_read = 1'b1;
    @(negedge clk);
    check("dmar_rvalid", {31'h0, dma_rvalid}, 32'h1);
    check("dmar_rdata", dma_rdata, 32'h7777_0007);
    check("dmar_gnt_pulse", {31'h0, dma_gnt}, 32'h0);
    check("dmar_cpu_stall", {31'h0, cpuBus.mem_stall}, 32'h1);
    @(posedge clk); #1;
    cpuBus.mem_read = 1'b0;
    @(negedge clk);
    check("dmar_rvalid_fall", {31'h0, dma_rvalid}, 32'h0);

    // DMA write into word 9, read back by the CPU.
    @(posedge clk); #1;
    dma_req   = 1'b1;
    dma_we    = 1'b1;
    dma_addr  = 12'd9;
    dma_wdata = 32'h0000_0099;
    @(negedge clk);
    check("dmaw_gnt", {31'h0, dma_gnt}, 32'h1);
    check("dmaw_we", {31'h0, ram_we}, 32'h1);
    @(posedge clk); #1;
    dma_req = 1'b0;
    cpuAccess(32'h0000_0024, 1'b1, 1'b0, 32'h0, stalls, rdata, we, word);
    check("dmaw_readback", rdata, 32'h0000_0099);

    // Starvation: back-to-back CPU RAM writes with DMA write requested throughout.
    firstGnt = 0;
    k        = 0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      cpuBus.mem_addr  = 32'h0000_0040 + 32'(4 * k);
      cpuBus.mem_wdata = 32'(k);
      cpuBus.mem_write = 1'b1;
      dma_req          = 1'b1;
      dma_we           = 1'b1;
      dma_addr         = 12'd100;
      dma_wdata        = 32'h0000_D0D0;
      @(negedge clk);
      if (dma_gnt && firstGnt == 0) begin
        firstGnt = c;
        check("starve_stall", {31'h0, cpuBus.mem_stall}, 32'h1);
        check("starve_addr", {20'h0, ram_addr}, 32'd100);
      end
      if (c == 18) begin
        check("starve_cleared_gnt", {31'h0, dma_gnt}, 32'h0);
        check("starve_cleared_stall", {31'h0, cpuBus.mem_stall}, 32'h0);
      end
      if (!cpuBus.mem_stall) k++;
    end
    check("starve_first_gnt", firstGnt, 17);
    @(posedge clk); #1;
    cpuBus.mem_write = 1'b0;
    dma_req          = 1'b0;
    cpuAccess(32'h0000_0190, 1'b1, 1'b0, 32'h0, stalls, rdata, we, word);
    check("starve_dma_data", rdata, 32'h0000_D0D0);
    cpuAccess(32'h0000_0080, 1'b1, 1'b0, 32'h0, stalls, rdata, we, word);
    check("starve_cpu_last", rdata, 32'h0000_0010);

    // Asynchronous reset in the middle of an IO wait.
    @(posedge clk); #1;
    cpuBus.mem_addr = 32'hFFFF_0008;
    cpuBus.mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstio_valid_before", {31'h0, io_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rstio_valid", {31'h0, io_valid}, 32'h0);
    check("rstio_err", {31'h0, io_err}, 32'h0);
    check("rstio_stall", {31'h0, cpuBus.mem_stall}, 32'h0);
    check("rstio_rdata", cpuBus.mem_rdata, 32'h0);
    cpuBus.mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstio_rdata_after", cpuBus.mem_rdata, 32'h0);
    check("rstio_valid_after", {31'h0, io_valid}, 32'h0);
    cpuAccess(32'h0000_0010, 1'b1, 1'b0, 32'h0, stalls, rdata, we, word);
    check("rstio_idle_stalls", stalls, 1);
    check("rstio_idle_rdata", rdata, 32'hA5A5_A5A5);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Responder end of the CPU data-memory interface: accepts the address/read/write/write-data request from the MEM stage and returns read data plus a stall.
- Serves a synchronous on-chip data RAM with 1-cycle read latency.
- Forwards addresses at or above IO_BASE to a valid/ready peripheral bus, with a timeout.
- Arbitrates a secondary DMA port into the RAM, with starvation protection.

Parameters:
- ADDR_W, 12, RAM word-address width (depth 2^ADDR_W words).
- IO_BASE, 32'hFFFF_0000, first byte address of the IO region.
- IO_TIMEOUT, 255, cycles allowed in IO_WAIT before abort.
- STARVE_MAX, 16, consecutive denied DMA-request cycles before DMA is forced ahead of the CPU.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  in  32  CPU request address.
- mem_read  in  1  CPU read request; held until the cycle mem_stall is low.
- mem_write  in  1  CPU write request.
- mem_wdata  in  32  CPU write data.
- mem_rdata  out  32  read data to the CPU.
- mem_stall  out  1  high: the CPU must hold its request.
- ram_addr  out  ADDR_W  RAM word address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after the address.
- io_addr  out  32  peripheral address (registered).
- io_wdata  out  32  peripheral write data (registered).
- io_we  out  1  peripheral write flag (registered).
- io_valid  out  1  peripheral request valid.
- io_ready  in  1  peripheral accepts / returns data.
- io_rdata  in  32  peripheral read data, valid with io_ready.
- io_err  out  1  1-cycle pulse on IO timeout.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA write flag.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  1-cycle grant pulse.
- dma_rdata  out  32  DMA read data.
- dma_rvalid  out  1  DMA read data valid.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; rdata_q=0; io_addr/io_wdata/io_we/io_valid=0; io_err=0; timeout and starve counters=0; dma_gnt=0; dma_rvalid=0.
  - ram_we and mem_stall are gated to 0 while rst_n is low.
  - Reset mid-transaction abandons it; there is no replay.
- Decode:
  - Request is IO when mem_addr >= IO_BASE, else RAM.
  - RAM word address is mem_addr[ADDR_W+1:2]; the upper RAM bits alias.
- CPU priority: if mem_write and mem_read are both high, the write is performed and the read is ignored.
- mem_rdata = ram_rdata in RAM_RD; = io_rdata in IO_WAIT when io_ready; otherwise rdata_q. rdata_q captures every delivered value.
- IDLE:
  - RAM write: ram_we=1 combinationally; no stall; stay IDLE.
  - RAM read: drive ram_addr; mem_stall=1; next state RAM_RD.
  - IO read or write: mem_stall=1; register addr/wdata/we; io_valid=1 from the next cycle; next state IO_WAIT.
  - No CPU request and dma_req: drive the DMA address; dma_gnt=1; ram_we=dma_we. Write stays IDLE; read goes to DMA_RD.
- RAM_RD: mem_stall=0; mem_rdata=ram_rdata; back to IDLE. CPU read latency is 2 cycles.
- IO_WAIT:
  - io_valid=1 and mem_stall=1 until io_ready.
  - Cycle io_ready=1: mem_stall=0; io_valid falls next cycle; back to IDLE.
  - Counter increments each IO_WAIT cycle. On reaching IO_TIMEOUT without io_ready: io_err=1; mem_stall=0; mem_rdata=32'hDEAD_BEEF (also loaded to rdata_q); back to IDLE.
- DMA_RD: dma_rvalid=1; dma_rdata=ram_rdata; back to IDLE. A CPU request in this cycle sees mem_stall=1.
- Starvation:
  - starve counter increments each cycle dma_req=1 without a grant, and clears on a grant.
  - At STARVE_MAX in IDLE, DMA is granted even with a CPU request present; that CPU request sees mem_stall=1 for the cycle.
  - The counter saturates at STARVE_MAX.
- Outside IDLE, a new CPU request always sees mem_stall=1, and DMA is never granted.

Test Plan:
- RAM write 0x0000_0010 data 0xCAFE_F00D (no stall), then read the same address -> ram_we pulse at word 4; read stalls 1 cycle; next cycle mem_rdata=0xCAFE_F00D, mem_stall=0.
- IO read 0xFFFF_0004, io_ready after 3 cycles with io_rdata=0x1234_5678 -> io_valid high 3 cycles; mem_stall low in the io_ready cycle; mem_rdata=0x1234_5678.
- IO write with io_ready never asserted -> io_err pulse after 255 IO_WAIT cycles; mem_rdata=0xDEAD_BEEF; state IDLE.
- dma_req read at word 7 while CPU idle -> dma_gnt pulse; next cycle dma_rvalid=1 with RAM contents.
- CPU issues back-to-back RAM writes with dma_req held -> DMA granted on cycle 17 (STARVE_MAX=16); CPU stalled that single cycle; counter cleared.
- rst_n low mid IO_WAIT -> io_valid=0 and io_err=0 immediately (async); after release state IDLE, rdata_q=0.
